fitness_feeder: RTL and testbench

FITNESS_FEEDER -- requirements
Module: fitness_feeder

---
 rtl/fitness_feeder_if.sv | 38 +++
 rtl/fitness_feeder.sv | 136 +++++++++++++
 tb/tb_fitness_feeder.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fitness_feeder_if.sv
// rtl/fitness_feeder_if.sv - coefficient, population-memory and evaluator signals of the fitness feeder.
interface fitness_feeder_if #(
  parameter int NUM_PARTICLE_TYPE = 3,
  parameter int DATA_WIDTH        = 4,
  parameter int INDIVIDUAL_LENGTH = 22,
  parameter int IDX_WIDTH         = 8
);
  logic                                                   start_i;
  logic [NUM_PARTICLE_TYPE*DATA_WIDTH-1:0]                self_energy_vec_i;
  logic [NUM_PARTICLE_TYPE*NUM_PARTICLE_TYPE*DATA_WIDTH-1:0] interact_matrix_i;
  logic                                                   pop_rd_en_o;
  logic [IDX_WIDTH-1:0]                                   pop_rd_addr_o;
  logic [INDIVIDUAL_LENGTH-1:0]                           pop_rd_data_i;
  logic [DATA_WIDTH-1:0]                                  self_energy_o;
  logic                                                   wrSelfEnergyValid_o;
  logic [DATA_WIDTH-1:0]                                  interact_energy_o;
  logic                                                   wrInteractEnergyValid_o;
  logic                                                   in_valid_o;
  logic [INDIVIDUAL_LENGTH-1:0]                           individual_vec_o;
  logic [IDX_WIDTH-1:0]                                   ind_idx_o;
  logic                                                   out_valid_i;
  logic                                                   busy_o;
  logic                                                   finish_o;

  modport master (
    input  start_i, self_energy_vec_i, interact_matrix_i, pop_rd_data_i, out_valid_i,
    output pop_rd_en_o, pop_rd_addr_o, self_energy_o, wrSelfEnergyValid_o,
           interact_energy_o, wrInteractEnergyValid_o, in_valid_o, individual_vec_o,
           ind_idx_o, busy_o, finish_o
  );

  modport slave (
    output start_i, self_energy_vec_i, interact_matrix_i, pop_rd_data_i, out_valid_i,
    input  pop_rd_en_o, pop_rd_addr_o, self_energy_o, wrSelfEnergyValid_o,
           interact_energy_o, wrInteractEnergyValid_o, in_valid_o, individual_vec_o,
           ind_idx_o, busy_o, finish_o
  );
endinterface

// File: rtl/fitness_feeder.sv
// rtl/fitness_feeder.sv - loads energy coefficients into the evaluator, streams the population, waits for all results.
module fitness_feeder #(
  parameter int NUM_PARTICLE_TYPE = 3,
  parameter int DATA_WIDTH        = 4,
  parameter int INDIVIDUAL_LENGTH = 22,
  parameter int POP_SIZE          = 50,
  parameter int IDX_WIDTH         = 8
) (
  input logic               clk_i,
  input logic               rst_n,
  fitness_feeder_if.master  bus
);
  localparam int NUM_IE = NUM_PARTICLE_TYPE * NUM_PARTICLE_TYPE;
  localparam int SUB_W  = $clog2(NUM_IE + 1);
  localparam logic [SUB_W-1:0]     SE_LAST   = SUB_W'(NUM_PARTICLE_TYPE);
  localparam logic [SUB_W-1:0]     IE_LAST   = SUB_W'(NUM_IE);
  localparam logic [IDX_WIDTH-1:0] ADDR_LAST = IDX_WIDTH'(POP_SIZE - 1);
  localparam logic [IDX_WIDTH-1:0] RES_DONE  = IDX_WIDTH'(POP_SIZE);

  typedef enum logic [2:0] {IDLE, LOAD_SE, GAP1, LOAD_IE, GAP2, STREAM, WAIT, DONE} state_t;

  state_t                                  state;
  logic [NUM_PARTICLE_TYPE*DATA_WIDTH-1:0] se_q;
  logic [NUM_IE*DATA_WIDTH-1:0]            ie_q;
  logic [SUB_W-1:0]                        sub;
  logic [IDX_WIDTH-1:0]                    res_cnt;
  logic [IDX_WIDTH-1:0]                    res_next;
  logic                                    wr_se_q, wr_ie_q, pop_en_q, in_valid_q, finish_q;
  logic [DATA_WIDTH-1:0]                   se_o_q, ie_o_q;
  logic [IDX_WIDTH-1:0]                    pop_addr_q, ind_idx_q;

  assign res_next = res_cnt + IDX_WIDTH'(bus.out_valid_i);

  // Each state branch sets the outputs that will be visible during the following cycle.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      se_q       <= '0;
      ie_q       <= '0;
      sub        <= '0;
      res_cnt    <= '0;
      wr_se_q    <= 1'b0;
      wr_ie_q    <= 1'b0;
      se_o_q     <= '0;
      ie_o_q     <= '0;
      pop_en_q   <= 1'b0;
      pop_addr_q <= '0;
      in_valid_q <= 1'b0;
      ind_idx_q  <= '0;
      finish_q   <= 1'b0;
    end else begin
      in_valid_q <= pop_en_q;
      ind_idx_q  <= pop_addr_q;
      if (state == STREAM || state == WAIT) begin
        res_cnt <= res_next;
      end
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            se_q    <= bus.self_energy_vec_i;
            ie_q    <= bus.interact_matrix_i;
            res_cnt <= '0;
            sub     <= SUB_W'(1);
            wr_se_q <= 1'b1;
            se_o_q  <= bus.self_energy_vec_i[DATA_WIDTH-1:0];
            state   <= LOAD_SE;
          end
        end
        LOAD_SE: begin
          if (sub == SE_LAST) begin
            wr_se_q <= 1'b0;
            se_o_q  <= '0;
            state   <= GAP1;
          end else begin
            se_o_q <= se_q[32'(sub)*DATA_WIDTH +: DATA_WIDTH];
            sub    <= sub + 1'b1;
          end
        end
        GAP1: begin
          sub     <= SUB_W'(1);
          wr_ie_q <= 1'b1;
          ie_o_q  <= ie_q[DATA_WIDTH-1:0];
          state   <= LOAD_IE;
        end
        LOAD_IE: begin
          if (sub == IE_LAST) begin
            wr_ie_q <= 1'b0;
            ie_o_q  <= '0;
            state   <= GAP2;
          end else begin
            ie_o_q <= ie_q[32'(sub)*DATA_WIDTH +: DATA_WIDTH];
            sub    <= sub + 1'b1;
          end
        end
        GAP2: begin
          pop_en_q   <= 1'b1;
          pop_addr_q <= '0;
          state      <= STREAM;
        end
        STREAM: begin
          if (pop_addr_q == ADDR_LAST) begin
            pop_en_q   <= 1'b0;
            pop_addr_q <= '0;
            state      <= WAIT;
          end else begin
            pop_addr_q <= pop_addr_q + 1'b1;
          end
        end
        WAIT: begin
          if (res_next == RES_DONE) begin
            finish_q <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          finish_q <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.self_energy_o           = se_o_q;
  assign bus.wrSelfEnergyValid_o     = wr_se_q;
  assign bus.interact_energy_o       = ie_o_q;
  assign bus.wrInteractEnergyValid_o = wr_ie_q;
  assign bus.pop_rd_en_o             = pop_en_q;
  assign bus.pop_rd_addr_o           = pop_addr_q;
  assign bus.in_valid_o              = in_valid_q;
  assign bus.ind_idx_o               = ind_idx_q;
  // Memory data arrives one cycle after the read, aligned with the delayed valid.
  assign bus.individual_vec_o        = in_valid_q ? bus.pop_rd_data_i : '0;
  assign bus.busy_o                  = (state != IDLE);
  assign bus.finish_o                = finish_q;
endmodule

// File: tb/tb_fitness_feeder.sv
// tb/tb_fitness_feeder.sv - timeline model of the feeder plus directed literal checks.
module tb_fitness_feeder;
  localparam int NPT = 3;
  localparam int DW  = 4;
  localparam int IL  = 22;
  localparam int P   = 50;
  localparam int IW  = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fitness_feeder_if #(.NUM_PARTICLE_TYPE(NPT), .DATA_WIDTH(DW), .INDIVIDUAL_LENGTH(IL), .IDX_WIDTH(IW)) bus();

  fitness_feeder #(.NUM_PARTICLE_TYPE(NPT), .DATA_WIDTH(DW), .INDIVIDUAL_LENGTH(IL),
                   .POP_SIZE(P), .IDX_WIDTH(IW)) dut (
    .clk_i (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;
  int   s_cyc   = 0;
  int   iv_cnt  = 0;
  int   fin_cnt = 0;
  logic hold_last = 1'b0;
  logic manual_ov = 1'b0;
  logic [IL-1:0] mem_q = '0;
  logic [3:0]    pipe_v = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Population memory: word = address, one-cycle read latency.
  always @(posedge clk) if (bus.pop_rd_en_o) mem_q <= IL'(bus.pop_rd_addr_o);
  assign bus.pop_rd_data_i = mem_q;

  // Evaluator stand-in: each individual returns a result four cycles later.
  always @(posedge clk)
    pipe_v <= {pipe_v[2:0], bus.in_valid_o && !(hold_last && bus.ind_idx_o == IW'(P-1))};
  assign bus.out_valid_i = pipe_v[3] | manual_ov;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model: t_m counts cycles since the accepted start edge (-1 when idle).
  int t_m  = -1;
  int rc_m = 0;
  bit fin_m = 1'b0;
  int se_m[NPT];
  int ie_m[NPT*NPT];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_m = -1; rc_m = 0; fin_m = 1'b0;
    end else if (t_m < 0) begin
      if (bus.start_i) begin
        for (int k = 0; k < NPT; k++) se_m[k] = int'(bus.self_energy_vec_i[k*DW +: DW]);
        for (int k = 0; k < NPT*NPT; k++) ie_m[k] = int'(bus.interact_matrix_i[k*DW +: DW]);
        t_m = 1; rc_m = 0;
      end
    end else if (fin_m) begin
      fin_m = 1'b0; t_m = -1;
    end else begin
      if (t_m >= 15 && bus.out_valid_i) rc_m++;
      if (t_m >= 15 + P && rc_m == P) fin_m = 1'b1;
      t_m++;
    end
  end

  always @(negedge clk) begin
    int  t;
    bit  e_se, e_ie, e_pop, e_iv;
    t     = t_m;
    e_se  = (t >= 1 && t <= NPT);
    e_ie  = (t >= NPT + 2 && t <= NPT + 1 + NPT*NPT);
    e_pop = (t >= 15 && t <= 14 + P);
    e_iv  = (t >= 16 && t <= 15 + P);
    chk("wr_se",    int'(bus.wrSelfEnergyValid_o), int'(e_se));
    chk("se_data",  int'(bus.self_energy_o), e_se ? se_m[t-1] : 0);
    chk("wr_ie",    int'(bus.wrInteractEnergyValid_o), int'(e_ie));
    chk("ie_data",  int'(bus.interact_energy_o), e_ie ? ie_m[t-5] : 0);
    chk("pop_en",   int'(bus.pop_rd_en_o), int'(e_pop));
    chk("pop_addr", int'(bus.pop_rd_addr_o), e_pop ? t - 15 : 0);
    chk("in_valid", int'(bus.in_valid_o), int'(e_iv));
    chk("ind_idx",  int'(bus.ind_idx_o), e_iv ? t - 16 : 0);
    chk("ind_vec",  int'(bus.individual_vec_o), e_iv ? t - 16 : 0);
    chk("busy",     int'(bus.busy_o), int'(t >= 0));
    chk("finish",   int'(bus.finish_o), int'(fin_m));
    chk("overlap",  int'((bus.wrSelfEnergyValid_o | bus.wrInteractEnergyValid_o) & bus.in_valid_o), 0);
    if (bus.in_valid_o) iv_cnt++;
    if (bus.finish_o)   fin_cnt++;
  end

  task automatic goto_rel(input int k);
    int tgt;
    tgt = s_cyc + k - 1;
    @(negedge clk);
    while (cyc < tgt) @(negedge clk);
    if (cyc != tgt) chk("goto_timing", cyc, tgt);
  endtask

  task automatic pulse_start();
    bus.start_i = 1'b1;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
  endtask

  task automatic run_start();
    @(negedge clk);
    pulse_start();
    s_cyc = cyc;
  endtask

  task automatic set_coeffs(input int se0, input int se1, input int se2, input int ie_base, input int ie_step);
    logic [NPT*DW-1:0]     sv;
    logic [NPT*NPT*DW-1:0] mv;
    sv = {DW'(se2), DW'(se1), DW'(se0)};
    for (int k = 0; k < NPT*NPT; k++) mv[k*DW +: DW] = DW'(ie_base + k*ie_step);
    bus.self_energy_vec_i = sv;
    bus.interact_matrix_i = mv;
  endtask

  initial begin
    int iv0, fin0;
    rst_n = 1'b0;
    bus.start_i = 1'b0;
    set_coeffs(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.busy_o), 0);
    chk("rst_pop_en", int'(bus.pop_rd_en_o), 0);
    chk("rst_wr_se", int'(bus.wrSelfEnergyValid_o), 0);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Run 1: self=[3,5,7], matrix 1..9; coefficients scrambled after the snapshot.
    set_coeffs(3, 5, 7, 1, 1);
    iv0 = iv_cnt; fin0 = fin_cnt;
    run_start();
    set_coeffs(15, 15, 15, 15, 0);
    goto_rel(1);  chk("r1_se0", int'(bus.self_energy_o), 3); chk("r1_wrse", int'(bus.wrSelfEnergyValid_o), 1);
    goto_rel(2);  chk("r1_se1", int'(bus.self_energy_o), 5);
    goto_rel(3);  chk("r1_se2", int'(bus.self_energy_o), 7);
    goto_rel(4);  chk("r1_gap1", int'(bus.wrSelfEnergyValid_o | bus.wrInteractEnergyValid_o), 0);
    goto_rel(5);  chk("r1_ie0", int'(bus.interact_energy_o), 1);
    goto_rel(7);  pulse_start();
    goto_rel(13); chk("r1_ie8", int'(bus.interact_energy_o), 9);
    goto_rel(14); chk("r1_gap2", int'(bus.wrInteractEnergyValid_o), 0);
    goto_rel(15); chk("r1_pop0", int'(bus.pop_rd_en_o), 1);
    goto_rel(16); chk("r1_iv0", int'(bus.in_valid_o), 1);
    goto_rel(30); pulse_start();
    goto_rel(64); chk("r1_addr49", int'(bus.pop_rd_addr_o), 49);
    goto_rel(65); chk("r1_vec49", int'(bus.individual_vec_o), 49);
    goto_rel(70); chk("r1_finish", int'(bus.finish_o), 1);
    goto_rel(71); chk("r1_idle", int'(bus.busy_o), 0);
    chk("r1_iv_count", iv_cnt - iv0, 50);
    chk("r1_fin_count", fin_cnt - fin0, 1);

    // Run 2: reset at stream address 20, then a full fresh run.
    fin0 = fin_cnt;
    set_coeffs(1, 2, 15, 15, -1);
    run_start();
    goto_rel(35); chk("r2_addr20", int'(bus.pop_rd_addr_o), 20);
    #2 rst_n = 1'b0;
    #1;
    chk("r2_rst_pop", int'(bus.pop_rd_en_o), 0);
    chk("r2_rst_addr", int'(bus.pop_rd_addr_o), 0);
    chk("r2_rst_iv", int'(bus.in_valid_o), 0);
    chk("r2_rst_busy", int'(bus.busy_o), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("r2_no_finish", fin_cnt - fin0, 0);
    iv0 = iv_cnt;
    run_start();
    goto_rel(3);  chk("r2_se2", int'(bus.self_energy_o), 15);
    goto_rel(13); chk("r2_ie8", int'(bus.interact_energy_o), 7);
    goto_rel(70); chk("r2_finish", int'(bus.finish_o), 1);
    goto_rel(71); chk("r2_idle", int'(bus.busy_o), 0);
    chk("r2_iv_count", iv_cnt - iv0, 50);

    // Run 3: 50th result withheld, then delivered late.
    hold_last = 1'b1;
    fin0 = fin_cnt;
    run_start();
    goto_rel(100);
    chk("r3_waiting", int'(bus.busy_o), 1);
    chk("r3_no_finish", fin_cnt - fin0, 0);
    manual_ov = 1'b1;
    @(posedge clk);
    #1 manual_ov = 1'b0;
    goto_rel(101); chk("r3_finish", int'(bus.finish_o), 1);
    goto_rel(102); chk("r3_idle", int'(bus.busy_o), 0);
    hold_last = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
